mem_bist: RTL and testbench
===========================

// Module: mem_bist
// PURPOSE
//  Built-in self-test master for the single-port synchronous memory on the membus.
//  Sits upstream of the memory and drives its addr/d/wr, in place of the free-running tester.
//  Runs a two-phase march on start: write P, read/check P, write ~P, read/check ~P.
//  Reports pass/fail, error count and the address of the first failing word.
// PARAMETERS
//  LEN   256    memory depth in words; address width AW = $clog2(LEN)
//  DW    8      data width
//  SEED  'hA5   DW-bit pattern seed; P(a) = a[DW-1:0] ^ SEED (a zero-extended if AW<DW)
// PORTS
//  clk             in   1      clock
//  rst             in   1      asynchronous reset, active-high
//  start           in   1      one-cycle request to begin a test; ignored while busy
//  abort           in   1      synchronous abort; returns to IDLE without done
//  busy            out  1      test in progress
//  done            out  1      test complete; held until next accepted start
//  pass            out  1      valid when done: 1 iff err_cnt == 0
//  err_cnt         out  EW     mismatches counted; EW = $clog2(2*LEN+1)
//  first_err_addr  out  AW     address of first mismatch; 0 if none
//  mem_addr        out  AW     to memory addr
//  mem_d           out  DW     to memory write data
//  mem_wr          out  1      to memory write enable
//  mem_q           in   DW     from memory read data; valid 1 clk after addr sampled
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, phase 0; busy/done/pass/mem_wr = 0;
//   mem_addr, mem_d, err_cnt, first_err_addr = 0; compare pipeline valids cleared.
//  All outputs registered. FSM: IDLE -> WR -> RD -> DRAIN -> (phase 0: WR, phase 1) -> DONE.
//  IDLE/DONE: start at edge t -> state WR, busy=1, done=0, pass=0, err_cnt and
//   first_err_addr cleared, phase=0, mem_addr=0, mem_wr=1.
//  WR: mem_wr=1, mem_d = phase ? ~P(mem_addr) : P(mem_addr); mem_addr += 1 each clk.
//   After addr LEN-1 presented: mem_addr=0, mem_wr=0, mem_d=0, state RD.
//  RD: mem_addr 0..LEN-1 one per clk, mem_wr=0; each issue pushes (addr, expected)
//   into a 2-stage pipe; stage 2 compares mem_q to expected.
//   Mismatch: err_cnt += 1; if first mismatch of this test, latch first_err_addr.
//  DRAIN: exactly 2 clks, mem_wr=0, lets last two reads compare; phase 0 -> phase=1, WR.
//  DONE: busy=0, done=1, pass = (err_cnt == 0); outputs held until next start.
//  Latency: done rises exactly 4*LEN+4 clks after the edge sampling start.
//  Address wrap: counter compares against LEN-1, correct for non-power-of-2 LEN.
//  err_cnt max 2*LEN; no saturation needed at width EW.
//  start while busy: ignored, no effect on any state.
//  abort (any busy state, priority over start same clk): next edge IDLE, busy=0,
//   done=0, mem_wr=0, pipe valids cleared; err_cnt/first_err_addr retain values.
//  start and abort both high in IDLE/DONE: abort wins, stays/returns IDLE.
//  rst mid-test: all outputs to reset values asynchronously; memory content undefined.
//  Memory is read-before-write; the BIST never reads and writes in the same cycle.
// STRUCTURE
//  Package mem_bist_pkg: state enum typedef {IDLE, WR, RD, DRAIN, DONE};
//   function pattern(addr, phase, seed) returning P or ~P.
//  Sub-module mem_bist_cmp: 2-stage (valid, addr, expected) pipe, comparator,
//   err_cnt and first_err_addr registers; clear/flush inputs from the FSM.
//  Top mem_bist: FSM, address/phase counters, memory drive registers.
// TESTING  (LEN=64, DW=8, SEED=8'hA5, ideal 1-clk-latency memory model)
//  Clean memory, start pulse -> done exactly 260 clks later, pass=1, err_cnt=0.
//  Model bit0 stuck-at-1 at addr 5 -> done, pass=0, err_cnt=1, first_err_addr=5.
//  Model stuck-at-0 word at addr 10 and 63 -> err_cnt=2 (one phase each failing
//   bits differ per phase; count per word-compare), first_err_addr=10; addr 63 checks drain.
//  start re-pulsed at clk 20 and 150 of a run -> ignored; done still at clk 260.
//  abort during phase-1 RD -> busy=0 next clk, done=0, mem_wr=0; new start runs full 260.
//  rst asserted mid-WR between edges -> mem_wr, busy drop to 0 before next edge;
//   after release, start runs clean: pass=1.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared types and the march data pattern for the memory BIST.
package mem_bist_pkg;

  typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, DONE} state_e;

  // Written/expected word: P(a) = a ^ seed, inverted in phase 1; the caller truncates to DW.
  function automatic logic [31:0] pattern(input logic [31:0] addr,
                                          input logic        phase,
                                          input logic [31:0] seed);
    logic [31:0] p;
    p = addr ^ seed;
    return phase ? ~p : p;
  endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-check pipe: captures (addr, expected) per issued read, compares against mem_q a cycle later.
module mem_bist_cmp
  import mem_bist_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int EW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_addr,
  input  logic [DW-1:0] i_push_exp,
  input  logic [DW-1:0] i_mem_q,
  output logic [EW-1:0] o_err_cnt,
  output logic [AW-1:0] o_first_err_addr
);

  localparam logic [EW-1:0] ONE_E = EW'(1);

  logic          r_vld_p1;
  logic [AW-1:0] r_addr_p1;
  logic [DW-1:0] r_exp_p1;
  logic          w_mis_p2;

  assign w_mis_p2 = r_vld_p1 && (i_mem_q != r_exp_p1);

  // stage p1: issued read address and its expected word
  always_ff @(posedge clk) begin
    r_addr_p1 <= i_push_addr;
    r_exp_p1  <= i_push_exp;
  end

  // stage p2: mem_q is now valid for the p1 entry; accumulate the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1         <= 1'b0;
      o_err_cnt        <= '0;
      o_first_err_addr <= '0;
    end else if (i_clear) begin
      r_vld_p1         <= 1'b0;
      o_err_cnt        <= '0;
      o_first_err_addr <= '0;
    end else if (i_flush) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= i_push;
      if (w_mis_p2) begin
        o_err_cnt <= o_err_cnt + ONE_E;
        if (o_err_cnt == '0) o_first_err_addr <= r_addr_p1;
      end
    end
  end

endmodule

// File: rtl/mem_bist.sv
// March BIST master: write P, read/check P, write ~P, read/check ~P over the whole memory.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter  int            LEN  = 256,
  parameter  int            DW   = 8,
  parameter  logic [DW-1:0] SEED = 'hA5,
  localparam int            AW   = $clog2(LEN),
  localparam int            EW   = $clog2(2*LEN+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [EW-1:0] err_cnt,
  output logic [AW-1:0] first_err_addr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_q
);

  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  state_e        r_state;
  logic          r_phase;
  logic          r_drain;
  logic [AW-1:0] w_addr_next;
  logic [DW-1:0] w_d_next;
  logic [DW-1:0] w_exp;
  logic          w_accept;
  logic          w_push;

  assign w_addr_next = mem_addr + AW'(1);
  assign w_d_next    = DW'(pattern(32'(w_addr_next), r_phase, 32'(SEED)));
  assign w_exp       = DW'(pattern(32'(mem_addr), r_phase, 32'(SEED)));
  assign w_accept    = ((r_state == IDLE) || (r_state == DONE)) && start && !abort;
  assign w_push      = (r_state == RD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_phase  <= 1'b0;
      r_drain  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      mem_addr <= '0;
      mem_d    <= '0;
      mem_wr   <= 1'b0;
    end else if (abort) begin
      r_state  <= IDLE;
      r_phase  <= 1'b0;
      r_drain  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      mem_addr <= '0;
      mem_d    <= '0;
      mem_wr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state  <= WR;
            r_phase  <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            mem_addr <= '0;
            mem_d    <= DW'(pattern(32'd0, 1'b0, 32'(SEED)));
            mem_wr   <= 1'b1;
          end
        end
        WR: begin
          if (mem_addr == LAST) begin
            r_state  <= RD;
            mem_addr <= '0;
            mem_d    <= '0;
            mem_wr   <= 1'b0;
          end else begin
            mem_addr <= w_addr_next;
            mem_d    <= w_d_next;
          end
        end
        RD: begin
          if (mem_addr == LAST) begin
            r_state  <= DRAIN;
            r_drain  <= 1'b0;
            mem_addr <= '0;
          end else begin
            mem_addr <= w_addr_next;
          end
        end
        DRAIN: begin
          // two cycles so the final read reaches the comparator before moving on
          if (!r_drain) begin
            r_drain <= 1'b1;
          end else if (!r_phase) begin
            r_state  <= WR;
            r_phase  <= 1'b1;
            mem_addr <= '0;
            mem_d    <= DW'(pattern(32'd0, 1'b1, 32'(SEED)));
            mem_wr   <= 1'b1;
          end else begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_cnt == '0);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mem_bist_cmp #(.AW(AW), .DW(DW), .EW(EW)) u_cmp (
    .clk              (clk),
    .rst              (rst),
    .i_clear          (w_accept),
    .i_flush          (abort),
    .i_push           (w_push),
    .i_push_addr      (mem_addr),
    .i_push_exp       (w_exp),
    .i_mem_q          (mem_q),
    .o_err_cnt        (err_cnt),
    .o_first_err_addr (first_err_addr)
  );

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: faulty-memory model with stuck bits, reference march computed in plain loops.
module tb_mem_bist;

  localparam int            LEN  = 64;
  localparam int            DW   = 8;
  localparam int            AW   = 6;
  localparam int            EW   = 8;
  localparam logic [DW-1:0] SEED = 8'hA5;
  localparam int            LAT  = 4*LEN + 4;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic          busy, done, pass, mem_wr;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] first_err_addr, mem_addr;
  logic [DW-1:0] mem_d, mem_q;

  logic [DW-1:0] mem   [LEN];
  logic [DW-1:0] and_m [LEN];
  logic [DW-1:0] or_m  [LEN];

  int n_tests = 0;
  int n_fail  = 0;

  mem_bist #(.LEN(LEN), .DW(DW), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .mem_addr(mem_addr), .mem_d(mem_d),
    .mem_wr(mem_wr), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Ideal read-before-write memory; stuck bits corrupt what is read back.
  always @(posedge clk) begin
    mem_q <= (mem[mem_addr] & and_m[mem_addr]) | or_m[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_d;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < LEN; a++) begin
      and_m[a] = '1;
      or_m[a]  = '0;
    end
  endtask

  // Reference: every word checked once per phase against P or ~P.
  task automatic ref_model(input int phases, output int exp_err, output int exp_first);
    logic [DW-1:0] p, rd;
    exp_err   = 0;
    exp_first = 0;
    for (int ph = 0; ph < phases; ph++)
      for (int a = 0; a < LEN; a++) begin
        p  = DW'(a) ^ SEED;
        if (ph == 1) p = ~p;
        rd = (p & and_m[a]) | or_m[a];
        if (rd != p) begin
          if (exp_err == 0) exp_first = a;
          exp_err++;
        end
      end
  endtask

  // Pulse start, then count edges until done; optional re-pulses sampled at edges p1/p2.
  task automatic run_test(input int p1, input int p2, output int lat);
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= LAT + 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      start = ((k == p1 - 1) || (k == p2 - 1));
    end
    start = 1'b0;
  endtask

  task automatic run_and_check(input string tag);
    int lat, e_err, e_first;
    ref_model(2, e_err, e_first);
    run_test(0, 0, lat);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_err_cnt"}, err_cnt, e_err);
    check({tag, "_first_err_addr"}, first_err_addr, e_first);
    check({tag, "_pass"}, pass, (e_err == 0));
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int lat, e_err, e_first, nf, a, b;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    clear_faults();
    for (int i = 0; i < LEN; i++) mem[i] = '0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_d", mem_d, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first_err", first_err_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_and_check("clean");

    clear_faults();
    or_m[5][0] = 1'b1;
    run_and_check("sa1_addr5");
    check("sa1_addr5_err_const", err_cnt, 1);
    check("sa1_addr5_first_const", first_err_addr, 5);

    clear_faults();
    and_m[10][0] = 1'b0;
    and_m[63][0] = 1'b0;
    run_and_check("sa0_10_63");
    check("sa0_err_const", err_cnt, 2);
    check("sa0_first_const", first_err_addr, 10);

    clear_faults();
    ref_model(2, e_err, e_first);
    run_test(20, 150, lat);
    check("repulse_latency", lat, LAT);
    check("repulse_pass", pass, 1);

    // abort in phase-1 read, with a phase-0 fault already counted
    clear_faults();
    or_m[5][0] = 1'b1;
    ref_model(1, e_err, e_first);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (199) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_mem_wr", mem_wr, 0);
    check("abort_err_kept", err_cnt, e_err);
    check("abort_first_kept", first_err_addr, e_first);
    repeat (3) @(posedge clk);
    #1 check("abort_stays_idle", busy, 0);
    clear_faults();
    run_and_check("after_abort");

    // async reset mid-write
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_mem_wr", mem_wr, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    run_and_check("after_rst");

    for (int it = 0; it < 4; it++) begin
      clear_faults();
      nf = $urandom_range(1, 3);
      for (int j = 0; j < nf; j++) begin
        a = $urandom_range(0, LEN - 1);
        b = $urandom_range(0, DW - 1);
        if ($urandom_range(0, 1) == 1) or_m[a][b] = 1'b1;
        else                           and_m[a][b] = 1'b0;
      end
      run_and_check($sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
